// File: rtl/io_trace_capture.sv
// io_trace_capture: samples a chip I/O probe vector every cycle and pushes
// timestamped records into a small FIFO for a downstream consumer.
//
// Optional feature macro: IO_TRACE_TIMESTAMP_EN
//   defined   - a free-running 32-bit cycle counter stamps each record
//   undefined - no counter is built, the timestamp field reads 0
//
// Parameters:
//   Width  - probe vector width
//   Depth  - FIFO entries (power of two, >= 2)
//   TsInit - counter value loaded by reset (normally 0)
//
// Ports:
//   clk_i          clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   enable_i       capture enable
//   change_only_i  1: record only when probe differs from last stored record
//   clear_i        synchronous flush of FIFO, overflow flag and drop counter
//   probe_i        sampled chip I/O vector
//   trace_o        {timestamp, probe} at FIFO head, 0 when empty
//   trace_valid_o  trace_o holds a record
//   trace_ready_i  consumer accepts the record
//   level_o        FIFO occupancy
//   overflow_o     sticky: at least one record dropped
//   drop_cnt_o     saturating dropped-record count
module io_trace_capture #(
    parameter int unsigned Width  = 61,
    parameter int unsigned Depth  = 8,
    parameter logic [31:0] TsInit = 32'h0000_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    change_only_i,
    input  logic                    clear_i,
    input  logic [Width-1:0]        probe_i,
    output logic [31+Width:0]       trace_o,
    output logic                    trace_valid_o,
    input  logic                    trace_ready_i,
    output logic [$clog2(Depth):0]  level_o,
    output logic                    overflow_o,
    output logic [15:0]             drop_cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned RecW = 32 + Width;
    localparam logic [PtrW:0]   FullLevel = Depth[PtrW:0];
    localparam logic [PtrW:0]   LevelOne  = 1;
    localparam logic [PtrW-1:0] PtrOne    = 1;

    logic [Width-1:0] probe_q;
    logic             enable_q;
    logic [Width-1:0] last_q;
    logic             first_q;
    logic [31:0]      ts;

    logic [RecW-1:0]  mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic cap_event, full, pop, wr_accept, drop;

`ifdef IO_TRACE_TIMESTAMP_EN
    logic [31:0] ts_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q <= TsInit;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end

    // ts_q was advanced by the same edge that loaded probe_q.
    assign ts = ts_q;
`else
    logic unused_ts_init;
    assign unused_ts_init = ^TsInit;
    assign ts = 32'h0000_0000;
`endif

    // Input sampling stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            probe_q  <= '0;
            enable_q <= 1'b0;
        end else begin
            probe_q  <= probe_i;
            enable_q <= enable_i;
        end
    end

    assign cap_event = enable_q && (!change_only_i || first_q || (probe_q != last_q));
    assign full      = (level_q == FullLevel);
    assign pop       = (level_q != '0) && trace_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_accept = cap_event && (!full || pop);
    assign drop      = cap_event && full && !pop;

    // Change-detection state only follows records that actually entered the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q  <= '0;
            first_q <= 1'b1;
        end else begin
            if (clear_i) begin
                first_q <= 1'b1;
            end else if (enable_i && !enable_q) begin
                first_q <= 1'b1;
            end else if (wr_accept) begin
                first_q <= 1'b0;
            end
            if (wr_accept && !clear_i) begin
                last_q <= probe_q;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            if (wr_accept && !pop) begin
                level_d = level_q + LevelOne;
            end else if (!wr_accept && pop) begin
                level_d = level_q - LevelOne;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: stale entries are hidden by level_q == 0.
    always_ff @(posedge clk_i) begin
        if (wr_accept && !clear_i) begin
            mem_q[wr_ptr_q] <= {ts, probe_q};
        end
    end

    assign trace_valid_o = (level_q != '0);
    assign trace_o       = trace_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o       = level_q;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_io_trace_capture.sv
// Directed bench for io_trace_capture. A second instance with a counter preset
// just below wrap shares the stimulus to exercise timestamp rollover.
module tb_io_trace_capture;

    localparam int unsigned Width = 61;
    localparam int unsigned Depth = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              change_only;
    logic              clear;
    logic [Width-1:0]  probe;
    logic              ready;

    logic [31+Width:0] trace, trace_w;
    logic              valid, valid_w;
    logic [3:0]        level, level_w;
    logic              overflow, overflow_w;
    logic [15:0]       drop, drop_w;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    logic [127:0] expq [$];

    always #5 clk = ~clk;

    io_trace_capture #(.Width(Width), .Depth(Depth)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .change_only_i(change_only),
        .clear_i(clear), .probe_i(probe), .trace_o(trace), .trace_valid_o(valid),
        .trace_ready_i(ready), .level_o(level), .overflow_o(overflow), .drop_cnt_o(drop)
    );

    io_trace_capture #(.Width(Width), .Depth(Depth), .TsInit(32'hFFFF_FFFD)) dut_w (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .change_only_i(change_only),
        .clear_i(clear), .probe_i(probe), .trace_o(trace_w), .trace_valid_o(valid_w),
        .trace_ready_i(ready), .level_o(level_w), .overflow_o(overflow_w),
        .drop_cnt_o(drop_w)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_ts(input logic [31:0] t);
`ifdef IO_TRACE_TIMESTAMP_EN
        return t;
`else
        return 32'h0 & t;
`endif
    endfunction

    function automatic logic [127:0] rec(input logic [31:0] t, input logic [Width-1:0] p);
        return {35'b0, exp_ts(t), p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int n);
        ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check($sformatf("drain_valid%0d", i), 128'(valid), 128'(1));
            check($sformatf("drain_rec%0d", i), 128'(trace), expq.pop_front());
            tick();
        end
        ready = 1'b0;
        check("drain_empty", 128'(level), 128'(0));
    endtask

    logic [Width-1:0] seq  [6];
    logic             keep [6];
    logic [Width-1:0] q    [7];
    logic [31:0]      ts_x;

    initial begin
        rst_n = 1'b0; enable = 1'b0; change_only = 1'b0; clear = 1'b0;
        probe = '0; ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;

        // Reset state
        check("rst_valid", 128'(valid), 128'(0));
        check("rst_level", 128'(level), 128'(0));
        check("rst_trace", 128'(trace), 128'(0));
        check("rst_ovf", 128'(overflow), 128'(0));
        check("rst_drop", 128'(drop), 128'(0));

        // Record every cycle, consumer always ready; samples at edges 1..3
        enable = 1'b1; change_only = 1'b0; ready = 1'b1; probe = 61'h1;
        tick();
        check("lat_valid_e1", 128'(valid), 128'(0));
        tick();
        check("lat_valid_e2", 128'(valid), 128'(1));
        check("lat_level_e2", 128'(level), 128'(1));
        check("rec0", 128'(trace), rec(32'd1, 61'h1));
        check("wrap0", 128'(trace_w), rec(32'hFFFF_FFFE, 61'h1));
        tick();
        check("rec1", 128'(trace), rec(32'd2, 61'h1));
        check("wrap1", 128'(trace_w), rec(32'hFFFF_FFFF, 61'h1));
        enable = 1'b0; probe = '0;
        tick();
        check("rec2", 128'(trace), rec(32'd3, 61'h1));
        check("wrap2", 128'(trace_w), rec(32'h0000_0000, 61'h1));
        check("stream_level", 128'(level), 128'(1));
        tick();
        check("stream_empty_valid", 128'(valid), 128'(0));
        check("stream_empty_trace", 128'(trace), 128'(0));

        // Change-only: A,A,A,B,B,A -> A,B,A
        seq[0] = 61'h0AAA_0000_1111; keep[0] = 1'b1;
        seq[1] = 61'h0AAA_0000_1111; keep[1] = 1'b0;
        seq[2] = 61'h0AAA_0000_1111; keep[2] = 1'b0;
        seq[3] = 61'h1BBB_2222_3333; keep[3] = 1'b1;
        seq[4] = 61'h1BBB_2222_3333; keep[4] = 1'b0;
        seq[5] = 61'h0AAA_0000_1111; keep[5] = 1'b1;
        ready = 1'b0; change_only = 1'b1; enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            probe = seq[i];
            if (keep[i]) expq.push_back(rec(cyc + 1, seq[i]));
            tick();
        end
        enable = 1'b0;
        tick();
        tick();
        check("chg_level", 128'(level), 128'(3));
        drain(3);

        // Overflow: 11 events into 8 entries, no consumer
        change_only = 1'b0; enable = 1'b1;
        for (int i = 0; i < 11; i++) begin
            probe = 61'h100 + 61'(i);
            if (i < 8) expq.push_back(rec(cyc + 1, probe));
            tick();
            if (i == 8) begin
                check("fill_level", 128'(level), 128'(8));
                check("fill_ovf", 128'(overflow), 128'(0));
            end
        end
        enable = 1'b0; probe = '0;
        tick();
        check("ovf_level", 128'(level), 128'(8));
        check("ovf_flag", 128'(overflow), 128'(1));
        check("ovf_drop", 128'(drop), 128'(3));

        // Full FIFO: write and pop in the same edge -> no drop
        enable = 1'b1; probe = 61'h1FF;
        ts_x = cyc + 1;
        tick();
        enable = 1'b0; ready = 1'b1;
        check("fullpop_head", 128'(trace), expq.pop_front());
        expq.push_back(rec(ts_x, 61'h1FF));
        tick();
        ready = 1'b0;
        check("fullpop_level", 128'(level), 128'(8));
        check("fullpop_drop", 128'(drop), 128'(3));
        drain(8);

        // Clear with a concurrent capture at level 5; then first_q forces a record
        for (int i = 0; i < 6; i++) q[i] = 61'h200 + 61'(i);
        q[6] = q[4];
        change_only = 1'b1; enable = 1'b1; ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            probe = q[i];
            if (i == 6) begin
                check("preclr_level", 128'(level), 128'(5));
                check("preclr_ovf", 128'(overflow), 128'(1));
                clear = 1'b1;
                expq.push_back(rec(cyc + 1, q[6]));
            end
            tick();
        end
        clear = 1'b0; enable = 1'b0;
        check("clr_level", 128'(level), 128'(0));
        check("clr_valid", 128'(valid), 128'(0));
        check("clr_ovf", 128'(overflow), 128'(0));
        check("clr_drop", 128'(drop), 128'(0));
        tick();
        check("postclr_level", 128'(level), 128'(1));
        drain(1);

        // Asynchronous reset discards stored records immediately
        change_only = 1'b0; enable = 1'b1; probe = 61'h3;
        repeat (3) tick();
        enable = 1'b0;
        check("prerst_level", 128'(level), 128'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_level", 128'(level), 128'(0));
        check("arst_valid", 128'(valid), 128'(0));
        check("arst_trace", 128'(trace), 128'(0));
        check("arst_level_w", 128'(level_w), 128'(0));
        check("arst_valid_w", 128'(valid_w), 128'(0));
        check("arst_ovf_w", 128'(overflow_w), 128'(0));
        check("arst_drop_w", 128'(drop_w), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("postrst_valid", 128'(valid), 128'(0));
        check("postrst_trace", 128'(trace), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
